// File: rtl/midi_parser_pkg.sv
// Shared MIDI constants, parser state type and the status-byte data-count lookup.
package midi_parser_pkg;

  localparam int unsigned MIDI_CMD_SIZE = 3;

  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_OFF    = 3'd0;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_NOTE_ON     = 3'd1;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_AFTERTOUCH  = 3'd2;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CC          = 3'd3;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PATCH_CHG   = 3'd4;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_CH_PRESSURE = 3'd5;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_PITCH_BEND  = 3'd6;
  localparam logic [MIDI_CMD_SIZE-1:0] MIDI_CMD_SYSTEM      = 3'd7;

  localparam logic [7:0] MIDI_SYSEX_START = 8'hF0;
  localparam logic [7:0] MIDI_SYSEX_END   = 8'hF7;

  typedef enum logic [1:0] {
    StIdle,
    StWaitD0,
    StWaitD1,
    StSysex
  } midi_state_e;

  // Number of data bytes that follow a status byte (only meaningful for status bytes).
  function automatic logic [1:0] data_count(input logic [7:0] status);
    logic [1:0] cnt;
    cnt = 2'd0;
    if (status[7:5] == 3'b110) begin
      cnt = 2'd1;                         // 0xC0-0xDF
    end else if (status[7:4] != 4'hF) begin
      cnt = 2'd2;                         // other channel messages
    end else if (status == 8'hF1 || status == 8'hF3) begin
      cnt = 2'd1;
    end else if (status == 8'hF2) begin
      cnt = 2'd2;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/midi_parser_if.sv
// Byte input strobe from the UART side and decoded-event outputs towards the voice generators.
interface midi_parser_if;
  import midi_parser_pkg::*;

  logic                     byte_in_rdy;
  logic [7:0]               byte_in;
  logic                     midi_rdy;
  logic [MIDI_CMD_SIZE-1:0] midi_cmd;
  logic [3:0]               midi_ch_sysn;
  logic [6:0]               midi_data0;
  logic [6:0]               midi_data1;

  // Byte source / event consumer side.
  modport master (
    output byte_in_rdy, byte_in,
    input  midi_rdy, midi_cmd, midi_ch_sysn, midi_data0, midi_data1
  );

  // Parser side.
  modport slave (
    input  byte_in_rdy, byte_in,
    output midi_rdy, midi_cmd, midi_ch_sysn, midi_data0, midi_data1
  );
endinterface

// File: rtl/midi_parser.sv
// MIDI byte-stream decoder: running status, interleaved real-time, sysex skipping.
// Emits one registered midi_rdy strobe per completed message; outputs hold until next emit.
module midi_parser
  import midi_parser_pkg::*;
#(
  parameter bit VEL0_IS_NOTE_OFF = 1'b1
) (
  input logic          clk,
  input logic          reset,
  midi_parser_if.slave bus
);

  midi_state_e              state_q;
  logic [7:0]               status_q;     // status of the message being assembled
  logic                     run_valid_q;  // status_q is a channel running status
  logic [6:0]               part_d0_q;    // first data byte of a two-byte message

  logic                     rdy_q;
  logic [MIDI_CMD_SIZE-1:0] cmd_q;
  logic [3:0]               ch_q;
  logic [6:0]               d0_q;
  logic [6:0]               d1_q;

  logic [7:0]               b;
  logic                     is_rt;
  logic                     first_data;
  logic [1:0]               cnt;
  logic [MIDI_CMD_SIZE-1:0] cmd_2b;
  midi_state_e              after_msg;

  assign b = bus.byte_in;

  // Decode helpers for the byte currently offered.
  always_comb begin
    is_rt      = (b >= 8'hF8);
    cnt        = data_count(status_q);
    first_data = (state_q == StWaitD0) || ((state_q == StIdle) && run_valid_q);
    after_msg  = run_valid_q ? StWaitD0 : StIdle;
    cmd_2b     = status_q[6:4];
    if (VEL0_IS_NOTE_OFF && (cmd_2b == MIDI_CMD_NOTE_ON) && (b[6:0] == 7'd0)) begin
      cmd_2b = MIDI_CMD_NOTE_OFF;
    end
  end

  // Parser FSM with registered event outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      status_q    <= '0;
      run_valid_q <= 1'b0;
      part_d0_q   <= '0;
      rdy_q       <= 1'b0;
      cmd_q       <= '0;
      ch_q        <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
    end else begin
      rdy_q <= 1'b0;
      if (bus.byte_in_rdy) begin
        if (is_rt) begin
          // Real-time bytes pass straight through without touching parser state.
          rdy_q <= 1'b1;
          cmd_q <= MIDI_CMD_SYSTEM;
          ch_q  <= b[3:0];
          d0_q  <= '0;
          d1_q  <= '0;
        end else if (b[7]) begin
          // Any status aborts a partial message or sysex and starts afresh.
          if (b < MIDI_SYSEX_START) begin
            status_q    <= b;
            run_valid_q <= 1'b1;
            state_q     <= StWaitD0;
          end else begin
            run_valid_q <= 1'b0;
            state_q     <= StIdle;
            case (b)
              MIDI_SYSEX_START: state_q <= StSysex;
              8'hF1, 8'hF2, 8'hF3: begin
                status_q <= b;
                state_q  <= StWaitD0;
              end
              8'hF6: begin
                rdy_q <= 1'b1;
                cmd_q <= MIDI_CMD_SYSTEM;
                ch_q  <= b[3:0];
                d0_q  <= '0;
                d1_q  <= '0;
              end
              default: ;  // 0xF4, 0xF5, 0xF7 dropped
            endcase
          end
        end else if (first_data) begin
          if (cnt == 2'd1) begin
            rdy_q   <= 1'b1;
            cmd_q   <= status_q[6:4];
            ch_q    <= status_q[3:0];
            d0_q    <= b[6:0];
            d1_q    <= '0;
            state_q <= after_msg;
          end else begin
            part_d0_q <= b[6:0];
            state_q   <= StWaitD1;
          end
        end else if (state_q == StWaitD1) begin
          rdy_q   <= 1'b1;
          cmd_q   <= cmd_2b;
          ch_q    <= status_q[3:0];
          d0_q    <= part_d0_q;
          d1_q    <= b[6:0];
          state_q <= after_msg;
        end
        // Remaining data bytes (idle without running status, or inside sysex) are discarded.
      end
    end
  end

  assign bus.midi_rdy     = rdy_q;
  assign bus.midi_cmd     = cmd_q;
  assign bus.midi_ch_sysn = ch_q;
  assign bus.midi_data0   = d0_q;
  assign bus.midi_data1   = d1_q;

endmodule

// File: tb/tb_midi_parser.sv
// Bench for midi_parser: two instances (velocity-0 conversion on/off) fed the same byte stream,
// a queue-based message model checked every cycle, plus literal per-test event lists.
module tb_midi_parser;
  import midi_parser_pkg::*;

  typedef logic [20:0] ev_t;   // {cmd, ch_sysn, data0, data1}
  typedef logic [21:0] obs_t;  // {rdy, ev}

  logic clk   = 1'b0;
  logic reset = 1'b1;

  midi_parser_if bus1 ();
  midi_parser_if bus0 ();

  assign bus0.byte_in_rdy = bus1.byte_in_rdy;
  assign bus0.byte_in     = bus1.byte_in;

  midi_parser #(.VEL0_IS_NOTE_OFF(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  midi_parser #(.VEL0_IS_NOTE_OFF(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  obs_t exp_cur1  = '0;
  obs_t exp_cur0  = '0;
  obs_t exp_next1 = '0;
  obs_t exp_next0 = '0;

  // Model state: current message status and collected data bytes.
  bit         m_have  = 1'b0;
  bit         m_run   = 1'b0;
  bit         m_sysex = 1'b0;
  logic [7:0] m_st    = '0;
  logic [6:0] m_data[$];

  ev_t mlog1[$], mlog0[$], dlog1[$], dlog0[$];
  ev_t e1[$], e0[$];
  logic [7:0] sb[$];

  function automatic ev_t ev(input logic [2:0] c, input logic [3:0] ch, input logic [7:0] d0,
                             input logic [7:0] d1);
    return {c, ch, d0[6:0], d1[6:0]};
  endfunction

  // Expected event (if any) produced by one input cycle.
  task automatic model(input bit rdy, input logic [7:0] b, input bit rst);
    ev_t e;
    bit  emit;
    int  need;
    exp_next1[21] = 1'b0;
    exp_next0[21] = 1'b0;
    if (rst) begin
      m_have = 0; m_run = 0; m_sysex = 0; m_data.delete();
      exp_next1 = '0;
      exp_next0 = '0;
      return;
    end
    if (!rdy) return;
    emit = 0;
    need = 0;
    e    = '0;
    if (b >= 8'hF8) begin
      emit = 1;
      e    = ev(3'd7, b[3:0], 8'h00, 8'h00);
    end else if (b[7]) begin
      m_data.delete();
      m_sysex = 0;
      if (b < 8'hF0) begin
        m_st = b; m_have = 1; m_run = 1;
      end else begin
        m_have = 0; m_run = 0;
        if (b == 8'hF0) m_sysex = 1;
        else if (b == 8'hF1 || b == 8'hF2 || b == 8'hF3) begin
          m_st = b; m_have = 1;
        end else if (b == 8'hF6) begin
          emit = 1;
          e    = ev(3'd7, 4'h6, 8'h00, 8'h00);
        end
      end
    end else if (m_have && !m_sysex) begin
      m_data.push_back(b[6:0]);
      need = ((m_st >= 8'hC0 && m_st <= 8'hDF) || m_st == 8'hF1 || m_st == 8'hF3) ? 1 : 2;
      if (m_data.size() == need) begin
        emit = 1;
        e    = {m_st[6:4], m_st[3:0], m_data[0], (need == 2) ? m_data[1] : 7'd0};
        m_data.delete();
        if (!m_run) m_have = 0;
      end
    end
    if (emit) begin
      exp_next0 = {1'b1, e};
      mlog0.push_back(e);
      if (e[20:18] == 3'd1 && need == 2 && e[6:0] == 7'd0) e[20:18] = 3'd0;
      exp_next1 = {1'b1, e};
      mlog1.push_back(e);
    end
  endtask

  // One clock cycle of stimulus, driven just after the rising edge.
  task automatic step(input bit rdy, input logic [7:0] b, input bit rst);
    @(posedge clk);
    #1;
    exp_cur1 = exp_next1;
    exp_cur0 = exp_next0;
    chk_en   = 1'b1;
    bus1.byte_in_rdy = rdy;
    bus1.byte_in     = b;
    reset            = rst;
    model(rdy, b, rst);
  endtask

  // Per-cycle comparison against the model; also records observed events.
  always @(negedge clk) begin
    if (chk_en) begin
      obs_t o1, o0;
      o1 = {bus1.midi_rdy, bus1.midi_cmd, bus1.midi_ch_sysn, bus1.midi_data0, bus1.midi_data1};
      o0 = {bus0.midi_rdy, bus0.midi_cmd, bus0.midi_ch_sysn, bus0.midi_data0, bus0.midi_data1};
      checks++;
      if (o1 !== exp_cur1) begin
        errors++;
        $display("FAIL cycle_vel0on t=%0t got %h required %h", $time, o1, exp_cur1);
      end
      checks++;
      if (o0 !== exp_cur0) begin
        errors++;
        $display("FAIL cycle_vel0off t=%0t got %h required %h", $time, o0, exp_cur0);
      end
      if (bus1.midi_rdy === 1'b1) dlog1.push_back(o1[20:0]);
      if (bus0.midi_rdy === 1'b1) dlog0.push_back(o0[20:0]);
    end
  end

  task automatic check_log(input string name, input ev_t got[$], input ev_t req[$]);
    bit bad;
    bad = (got.size() != req.size());
    for (int i = 0; i < got.size() && !bad; i++) if (got[i] !== req[i]) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s got %0d events (first %h) required %0d events (first %h)", name,
               got.size(), (got.size() > 0) ? got[0] : 21'h0, req.size(),
               (req.size() > 0) ? req[0] : 21'h0);
    end
  endtask

  task automatic begin_test();
    mlog1.delete(); mlog0.delete(); dlog1.delete(); dlog0.delete();
  endtask

  task automatic end_test(input string name);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    check_log({name, " model_on"}, mlog1, e1);
    check_log({name, " dut_on"}, dlog1, e1);
    check_log({name, " model_off"}, mlog0, e0);
    check_log({name, " dut_off"}, dlog0, e0);
  endtask

  task automatic run_test(input string name, input int gap);
    begin_test();
    foreach (sb[i]) begin
      step(1'b1, sb[i], 1'b0);
      repeat (gap) step(1'b0, 8'h00, 1'b0);
    end
    end_test(name);
  endtask

  initial begin
    bus1.byte_in_rdy = 1'b0;
    bus1.byte_in     = 8'h00;
    repeat (3) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    #1;
    checks++;
    if ({bus1.midi_rdy, bus1.midi_cmd, bus1.midi_ch_sysn, bus1.midi_data0, bus1.midi_data1}
        !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b%h%h%h%h required all zero", bus1.midi_rdy,
               bus1.midi_cmd, bus1.midi_ch_sysn, bus1.midi_data0, bus1.midi_data1);
    end

    sb = '{8'h90, 8'h3C, 8'h64};
    e1.delete(); e1.push_back(ev(1, 0, 8'h3C, 8'h64)); e0 = e1;
    run_test("note_on", 1);

    sb = '{8'h93, 8'h40, 8'h50, 8'h42, 8'h51};
    e1.delete(); e1.push_back(ev(1, 3, 8'h40, 8'h50)); e1.push_back(ev(1, 3, 8'h42, 8'h51));
    e0 = e1;
    run_test("running_status", 2);

    sb = '{8'h90, 8'h3C, 8'hF8, 8'h64};
    e1.delete(); e1.push_back(ev(7, 8, 8'h00, 8'h00)); e1.push_back(ev(1, 0, 8'h3C, 8'h64));
    e0 = e1;
    run_test("realtime_mid_msg", 1);

    sb = '{8'h91, 8'h3C, 8'h00};
    e1.delete(); e1.push_back(ev(0, 1, 8'h3C, 8'h00));
    e0.delete(); e0.push_back(ev(1, 1, 8'h3C, 8'h00));
    run_test("vel0", 1);

    sb = '{8'hC5, 8'h07};
    e1.delete(); e1.push_back(ev(4, 5, 8'h07, 8'h00)); e0 = e1;
    run_test("patch_chg", 1);

    sb = '{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h45};
    e1.delete(); e0.delete();
    run_test("sysex_drop", 1);

    // Reset between status/data0 and data1.
    begin_test();
    step(1'b1, 8'h90, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h64, 1'b0);
    e1.delete(); e0.delete();
    end_test("reset_mid_msg");

    sb = '{8'h80, 8'h3C, 8'h40};
    e1.delete(); e1.push_back(ev(0, 0, 8'h3C, 8'h40)); e0 = e1;
    run_test("back_to_back", 0);

    sb = '{8'hF6};
    e1.delete(); e1.push_back(ev(7, 6, 8'h00, 8'h00)); e0 = e1;
    run_test("tune_req", 0);

    sb = '{8'hF2, 8'h01, 8'h02, 8'h03};
    e1.delete(); e1.push_back(ev(7, 2, 8'h01, 8'h02)); e0 = e1;
    run_test("song_pos_then_idle_data", 0);

    sb = '{8'hE2, 8'h00, 8'h40, 8'hF4, 8'h10};
    e1.delete(); e1.push_back(ev(6, 2, 8'h00, 8'h40)); e0 = e1;
    run_test("bend_then_f4", 0);

    sb = '{8'hF0, 8'h11, 8'hFE, 8'h90, 8'h3C, 8'h64};
    e1.delete(); e1.push_back(ev(7, 14, 8'h00, 8'h00)); e1.push_back(ev(1, 0, 8'h3C, 8'h64));
    e0 = e1;
    run_test("sysex_abort", 0);

    sb = '{8'h90, 8'h3C, 8'hB1, 8'h07, 8'h08, 8'hF1, 8'h05, 8'h06};
    e1.delete(); e1.push_back(ev(3, 1, 8'h07, 8'h08)); e1.push_back(ev(7, 1, 8'h05, 8'h00));
    e0 = e1;
    run_test("drop_partial_and_f1", 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
